auth_ctrl: RTL and testbench
============================

Name: auth_ctrl

Overview:
- Initiator-side controller for the user-record SRAM (SYNCSRAM).
- Accepts login and change-password requests, reads the user record (16b password, 4b try count, admin bit, lock bit), compares passwords, then writes back the try count, lock bit and new password as needed.
- Sits between the keypad/UI front end and the SRAM; it is the only SRAM master.

Parameters:
- ADDR_W, 12, user-record address width.
- PASS_W, 16, password width.
- CNT_W, 4, try-count width.
- MAX_TRIES, 3, consecutive failures that set the lock bit; legal range 1..15.
- RD_LAT, 1, SRAM read latency in cycles from the cs/addr sample edge to valid read data; legal range 1..4.

Ports:
- clk in 1: system clock, rising edge.
- rst in 1: asynchronous, active-low reset.
- req in 1: start request; sampled only in IDLE.
- op in 1: 0 = login, 1 = change password.
- user_id in ADDR_W: record address.
- pass_try in PASS_W: password entered by the user.
- pass_new in PASS_W: replacement password; used only when op=1.
- busy out 1: high from the cycle after acceptance through DONE.
- done out 1: one-cycle pulse; results valid in the same cycle.
- status out 2: 00 OK, 01 BAD_PASS, 10 LOCKED (already locked), 11 LOCKED_NOW (this failure set the lock).
- is_admin out 1: admin bit of the record; meaningful only when status=OK.
- tries out CNT_W: try count after update.
- mem_cs out 1: SRAM chip select.
- mem_pass_rw / mem_count_rw / mem_admin_rw / mem_lock_rw out 1 each: 0 = read, 1 = write.
- mem_addr out ADDR_W: SRAM address.
- mem_pass_wr out PASS_W, mem_count_wr out CNT_W, mem_admin_wr out 1, mem_lock_wr out 1: SRAM write data.
- mem_pass_rd in PASS_W, mem_count_rd in CNT_W, mem_admin_rd in 1, mem_lock_rd in 1: SRAM read data.

Behaviour:
- Reset values: state=IDLE; busy, done, mem_cs, all mem_*_rw = 0; status=00; is_admin=0; tries=0; mem_addr and all mem_*_wr = 0.
- FSM states: IDLE, RD, CHK, WR, DONE.
- IDLE:
  - If req=1, latch op, user_id, pass_try and pass_new, then go to RD.
  - req is ignored in every other state; there is no queueing.
- RD:
  - Held for exactly RD_LAT cycles.
  - mem_cs=1, all rw=0, mem_addr = latched user_id.
- CHK:
  - mem_cs=0; sample mem_*_rd; register the decision. Priority order:
  - (a) lock_rd=1: status=LOCKED, no write, tries=count_rd.
  - (b) pass_rd == pass_try:
    - status=OK; is_admin=admin_rd; new count = 0.
    - count write is enabled only if count_rd != 0.
    - pass write is enabled only if op=1, with mem_pass_wr=pass_new.
  - (c) mismatch:
    - new count = count_rd+1, saturating at 15.
    - Always write count.
    - If new count >= MAX_TRIES: also write lock=1, status=LOCKED_NOW.
    - Otherwise status=BAD_PASS.
    - op=1 never writes the password on a mismatch.
- WR:
  - Exactly one cycle.
  - mem_cs=1 only if at least one write is enabled; each mem_*_rw=1 only for its enabled field; admin is never written (mem_admin_rw=0).
  - mem_addr still equals user_id.
- DONE: done=1 for one cycle; status, is_admin and tries hold until the next DONE; return to IDLE.
- Fixed latency: req sampled in cycle T gives done in cycle T+RD_LAT+3 (T+4 at default), independent of outcome.
- Back-to-back: a new req may be sampled in the first IDLE cycle after DONE.
- Reset mid-operation:
  - All mem strobes drop immediately (async), the FSM goes to IDLE, and no done is issued.
  - Reset asserted during WR aborts the write; a partial record update is acceptable.
- Width rules:
  - Comparison is over the full PASS_W bits.
  - The count increment is CNT_W wide with explicit saturation; no wrap from 15 to 0.
  - Compare new count >= MAX_TRIES unsigned.

Decomposition:
- Package auth_pkg:
  - FSM state enum.
  - Status code constants (ST_OK, ST_BAD, ST_LOCKED, ST_LOCKED_NOW).
  - Width constants (ADDR_W, PASS_W, CNT_W).
  - RW_READ=0, RW_WRITE=1.
- One combinational sub-module, auth_decide.
  - Inputs: read record, op, pass_try, MAX_TRIES.
  - Outputs: status, new count, and the write-enable flags for count, lock and pass.
- The FSM, latches and SRAM drive stay in auth_ctrl.

Test Plan:
- Login OK, clean record: record 0x005 = {pass 0xBEEF, cnt 0, adm 1, lock 0}, req op=0 pass_try=0xBEEF → done at T+4, status=00, is_admin=1, tries=0, mem_cs=0 in WR (no write).
- Failure then lockout: record {0x1234, cnt 1, adm 0, lock 0}, pass_try=0x1235 twice →
  - 1st: status=01, tries=2, one WR cycle with mem_count_rw=1 and mem_count_wr=2.
  - 2nd: status=11, tries=3, count=3 and lock=1 written.
- Already locked: lock=1, correct password → status=10, no write cycle; record unchanged on read-back.
- Change password: {0xAAAA, cnt 2}, op=1 pass_try=0xAAAA pass_new=0x5555 → status=00; pass=0x5555 and cnt=0 written together in one WR cycle. Same request with a wrong pass_try → pass unchanged, count incremented.
- Saturation and stray req:
  - Record cnt=15 with MAX_TRIES=15 (locked=0) and a wrong password → count stays 15, lock set.
  - req pulsed while busy → ignored, only one done.
- Reset during RD/WR: rst low mid-transaction → mem_cs=0 and busy=0 immediately, no done pulse; the next req completes normally.

Source files
------------

// File: rtl/auth_pkg.sv
// Shared types and constants for the user-record authentication controller.
// Record layout mirrors the SRAM fields: password, try count, admin bit, lock bit.
package auth_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned PASS_W = 16;
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0] ST_OK         = 2'b00;
  localparam logic [1:0] ST_BAD        = 2'b01;
  localparam logic [1:0] ST_LOCKED     = 2'b10;
  localparam logic [1:0] ST_LOCKED_NOW = 2'b11;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StChk,
    StWr,
    StDone
  } state_e;

  typedef struct packed {
    logic [PASS_W-1:0] pass;
    logic [CNT_W-1:0]  count;
    logic              admin;
    logic              lock;
  } rec_t;

  // Saturating increment: a maxed-out count must never wrap back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/auth_decide.sv
// Combinational verdict on one user record: outcome status, updated try count
// and which record fields must be written back.
module auth_decide
  import auth_pkg::*;
#(
  parameter int unsigned MaxTries = 3
) (
  input  rec_t              rec_i,
  input  logic              op_i,
  input  logic [PASS_W-1:0] pass_try_i,
  output logic [1:0]        status_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              admin_o,
  output logic              wr_count_o,
  output logic              wr_lock_o,
  output logic              wr_pass_o
);

  logic [CNT_W-1:0] inc;

  assign inc = sat_inc(rec_i.count);

  always_comb begin
    status_o   = ST_BAD;
    count_o    = rec_i.count;
    admin_o    = 1'b0;
    wr_count_o = 1'b0;
    wr_lock_o  = 1'b0;
    wr_pass_o  = 1'b0;
    if (rec_i.lock) begin
      status_o = ST_LOCKED;
    end else if (rec_i.pass == pass_try_i) begin
      status_o   = ST_OK;
      count_o    = '0;
      admin_o    = rec_i.admin;
      wr_count_o = (rec_i.count != '0);
      wr_pass_o  = op_i;
    end else begin
      count_o    = inc;
      wr_count_o = 1'b1;
      if ({{(32 - CNT_W){1'b0}}, inc} >= MaxTries) begin
        wr_lock_o = 1'b1;
        status_o  = ST_LOCKED_NOW;
      end
    end
  end

endmodule

// File: rtl/auth_ctrl.sv
// Login / change-password controller: reads a user record from SRAM, decides,
// writes back count/lock/password, and reports the outcome with a done pulse.
module auth_ctrl
  import auth_pkg::*;
#(
  parameter int unsigned MaxTries = 3,
  parameter int unsigned RdLat    = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  input  logic              op_i,
  input  logic [ADDR_W-1:0] user_id_i,
  input  logic [PASS_W-1:0] pass_try_i,
  input  logic [PASS_W-1:0] pass_new_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        status_o,
  output logic              is_admin_o,
  output logic [CNT_W-1:0]  tries_o,
  output logic              mem_cs_o,
  output logic              mem_pass_rw_o,
  output logic              mem_count_rw_o,
  output logic              mem_admin_rw_o,
  output logic              mem_lock_rw_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [PASS_W-1:0] mem_pass_wr_o,
  output logic [CNT_W-1:0]  mem_count_wr_o,
  output logic              mem_admin_wr_o,
  output logic              mem_lock_wr_o,
  input  logic [PASS_W-1:0] mem_pass_rd_i,
  input  logic [CNT_W-1:0]  mem_count_rd_i,
  input  logic              mem_admin_rd_i,
  input  logic              mem_lock_rd_i
);

  localparam logic [1:0] RdLast = 2'(RdLat - 1);

  state_e            state_q, state_d;
  logic [1:0]        rd_cnt_q, rd_cnt_d;
  logic              op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PASS_W-1:0] pass_try_q, pass_try_d;
  logic [PASS_W-1:0] pass_new_q, pass_new_d;
  // Decision from CHK; only copied to the visible outputs on entry to DONE.
  logic [1:0]        dec_status_q, dec_status_d;
  logic [CNT_W-1:0]  dec_count_q, dec_count_d;
  logic              dec_admin_q, dec_admin_d;
  logic              wr_count_q, wr_count_d;
  logic              wr_lock_q, wr_lock_d;
  logic              wr_pass_q, wr_pass_d;
  logic [1:0]        status_q, status_d;
  logic              admin_q, admin_d;
  logic [CNT_W-1:0]  tries_q, tries_d;

  rec_t              rd_rec;
  logic [1:0]        dec_status;
  logic [CNT_W-1:0]  dec_count;
  logic              dec_admin, dec_wr_count, dec_wr_lock, dec_wr_pass;

  assign rd_rec = {mem_pass_rd_i, mem_count_rd_i, mem_admin_rd_i, mem_lock_rd_i};

  auth_decide #(
    .MaxTries(MaxTries)
  ) u_decide (
    .rec_i     (rd_rec),
    .op_i      (op_q),
    .pass_try_i(pass_try_q),
    .status_o  (dec_status),
    .count_o   (dec_count),
    .admin_o   (dec_admin),
    .wr_count_o(dec_wr_count),
    .wr_lock_o (dec_wr_lock),
    .wr_pass_o (dec_wr_pass)
  );

  always_comb begin
    state_d      = state_q;
    rd_cnt_d     = rd_cnt_q;
    op_d         = op_q;
    addr_d       = addr_q;
    pass_try_d   = pass_try_q;
    pass_new_d   = pass_new_q;
    dec_status_d = dec_status_q;
    dec_count_d  = dec_count_q;
    dec_admin_d  = dec_admin_q;
    wr_count_d   = wr_count_q;
    wr_lock_d    = wr_lock_q;
    wr_pass_d    = wr_pass_q;
    status_d     = status_q;
    admin_d      = admin_q;
    tries_d      = tries_q;
    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          op_d       = op_i;
          addr_d     = user_id_i;
          pass_try_d = pass_try_i;
          pass_new_d = pass_new_i;
          rd_cnt_d   = '0;
          state_d    = StRd;
        end
      end
      StRd: begin
        if (rd_cnt_q == RdLast) state_d = StChk;
        else                    rd_cnt_d = rd_cnt_q + 2'd1;
      end
      StChk: begin
        dec_status_d = dec_status;
        dec_count_d  = dec_count;
        dec_admin_d  = dec_admin;
        wr_count_d   = dec_wr_count;
        wr_lock_d    = dec_wr_lock;
        wr_pass_d    = dec_wr_pass;
        state_d      = StWr;
      end
      StWr: begin
        status_d = dec_status_q;
        admin_d  = dec_admin_q;
        tries_d  = dec_count_q;
        state_d  = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      rd_cnt_q     <= '0;
      op_q         <= 1'b0;
      addr_q       <= '0;
      pass_try_q   <= '0;
      pass_new_q   <= '0;
      dec_status_q <= ST_OK;
      dec_count_q  <= '0;
      dec_admin_q  <= 1'b0;
      wr_count_q   <= 1'b0;
      wr_lock_q    <= 1'b0;
      wr_pass_q    <= 1'b0;
      status_q     <= ST_OK;
      admin_q      <= 1'b0;
      tries_q      <= '0;
    end else begin
      state_q      <= state_d;
      rd_cnt_q     <= rd_cnt_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      pass_try_q   <= pass_try_d;
      pass_new_q   <= pass_new_d;
      dec_status_q <= dec_status_d;
      dec_count_q  <= dec_count_d;
      dec_admin_q  <= dec_admin_d;
      wr_count_q   <= wr_count_d;
      wr_lock_q    <= wr_lock_d;
      wr_pass_q    <= wr_pass_d;
      status_q     <= status_d;
      admin_q      <= admin_d;
      tries_q      <= tries_d;
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    mem_cs_o       = 1'b0;
    mem_pass_rw_o  = RW_READ;
    mem_count_rw_o = RW_READ;
    mem_admin_rw_o = RW_READ;
    mem_lock_rw_o  = RW_READ;
    if (state_q == StRd) begin
      mem_cs_o = 1'b1;
    end else if (state_q == StWr) begin
      mem_cs_o       = wr_count_q | wr_lock_q | wr_pass_q;
      mem_pass_rw_o  = wr_pass_q ? RW_WRITE : RW_READ;
      mem_count_rw_o = wr_count_q ? RW_WRITE : RW_READ;
      mem_lock_rw_o  = wr_lock_q ? RW_WRITE : RW_READ;
    end
  end

  assign busy_o         = (state_q != StIdle);
  assign done_o         = (state_q == StDone);
  assign status_o       = status_q;
  assign is_admin_o     = admin_q;
  assign tries_o        = tries_q;
  assign mem_addr_o     = addr_q;
  assign mem_pass_wr_o  = pass_new_q;
  assign mem_count_wr_o = dec_count_q;
  assign mem_admin_wr_o = 1'b0;
  assign mem_lock_wr_o  = wr_lock_q;

endmodule

// File: tb/tb_auth_ctrl.sv
// Bench for auth_ctrl: two instances (MaxTries 3/RdLat 1 and MaxTries 15/RdLat 3)
// share stimulus; each has its own SRAM model and record-level reference model.
module tb_auth_ctrl;

  typedef struct packed {
    logic [15:0] pass;
    logic [3:0]  cnt;
    logic        adm;
    logic        lck;
  } mrec_t;

  localparam mrec_t Poison = '{pass: 16'hDEAD, cnt: 4'hF, adm: 1'b1, lck: 1'b1};

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req = 1'b0, op = 1'b0;
  logic [11:0] user_id = '0;
  logic [15:0] pass_try = '0, pass_new = '0;

  logic        busy [2], done [2], is_admin [2], cs [2];
  logic        prw [2], crw [2], arw [2], lrw [2], awr [2], lwr [2];
  logic [1:0]  status [2];
  logic [3:0]  tries [2], cwr [2], crd [2];
  logic [11:0] addr [2];
  logic [15:0] pwr [2], prd [2];
  logic        ard [2], lrd [2];

  mrec_t       sram [2][4096];
  mrec_t       pipe [2][3];
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = '0;
  mrec_t       pl_rec = '0;

  int n_vec = 0, n_err = 0;
  int rp [2][8], rc [2][8], ra [2][8], rl [2][8];
  int max_tries [2] = '{3, 15};
  int rd_lat [2] = '{1, 3};
  logic [11:0] slot_addr [8] = '{12'h005, 12'h123, 12'h7FF, 12'hABC,
                                 12'h000, 12'hFFF, 12'h0F0, 12'h555};

  always #5 clk_i = ~clk_i;

  auth_ctrl #(.MaxTries(3), .RdLat(1)) u_dut_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req), .op_i(op), .user_id_i(user_id),
    .pass_try_i(pass_try), .pass_new_i(pass_new), .busy_o(busy[0]), .done_o(done[0]),
    .status_o(status[0]), .is_admin_o(is_admin[0]), .tries_o(tries[0]), .mem_cs_o(cs[0]),
    .mem_pass_rw_o(prw[0]), .mem_count_rw_o(crw[0]), .mem_admin_rw_o(arw[0]),
    .mem_lock_rw_o(lrw[0]), .mem_addr_o(addr[0]), .mem_pass_wr_o(pwr[0]),
    .mem_count_wr_o(cwr[0]), .mem_admin_wr_o(awr[0]), .mem_lock_wr_o(lwr[0]),
    .mem_pass_rd_i(prd[0]), .mem_count_rd_i(crd[0]), .mem_admin_rd_i(ard[0]),
    .mem_lock_rd_i(lrd[0])
  );

  auth_ctrl #(.MaxTries(15), .RdLat(3)) u_dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req), .op_i(op), .user_id_i(user_id),
    .pass_try_i(pass_try), .pass_new_i(pass_new), .busy_o(busy[1]), .done_o(done[1]),
    .status_o(status[1]), .is_admin_o(is_admin[1]), .tries_o(tries[1]), .mem_cs_o(cs[1]),
    .mem_pass_rw_o(prw[1]), .mem_count_rw_o(crw[1]), .mem_admin_rw_o(arw[1]),
    .mem_lock_rw_o(lrw[1]), .mem_addr_o(addr[1]), .mem_pass_wr_o(pwr[1]),
    .mem_count_wr_o(cwr[1]), .mem_admin_wr_o(awr[1]), .mem_lock_wr_o(lwr[1]),
    .mem_pass_rd_i(prd[1]), .mem_count_rd_i(crd[1]), .mem_admin_rd_i(ard[1]),
    .mem_lock_rd_i(lrd[1])
  );

  // SRAM models: read data appears rd_lat edges after the sampled read; idle
  // cycles load a poison record so a too-early sample is visible.
  always_ff @(posedge clk_i) begin
    for (int d = 0; d < 2; d++) begin
      pipe[d][1] <= pipe[d][0];
      pipe[d][2] <= pipe[d][1];
      if (cs[d] && !(prw[d] | crw[d] | arw[d] | lrw[d])) pipe[d][0] <= sram[d][addr[d]];
      else                                            pipe[d][0] <= Poison;
      if (cs[d] && prw[d]) sram[d][addr[d]].pass <= pwr[d];
      if (cs[d] && crw[d]) sram[d][addr[d]].cnt  <= cwr[d];
      if (cs[d] && arw[d]) sram[d][addr[d]].adm  <= awr[d];
      if (cs[d] && lrw[d]) sram[d][addr[d]].lck  <= lwr[d];
      if (pl_en) sram[d][pl_addr] <= pl_rec;
    end
  end

  assign prd[0] = pipe[0][0].pass;
  assign crd[0] = pipe[0][0].cnt;
  assign ard[0] = pipe[0][0].adm;
  assign lrd[0] = pipe[0][0].lck;
  assign prd[1] = pipe[1][2].pass;
  assign crd[1] = pipe[1][2].cnt;
  assign ard[1] = pipe[1][2].adm;
  assign lrd[1] = pipe[1][2].lck;

  task automatic check(input string tag, input int d, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, d, obs, exp);
    end
  endtask

  task automatic preload(input int s, input int p, input int c, input int a, input int l);
    for (int d = 0; d < 2; d++) begin
      rp[d][s] = p; rc[d][s] = c; ra[d][s] = a; rl[d][s] = l;
    end
    @(negedge clk_i);
    pl_en   = 1'b1;
    pl_addr = slot_addr[s];
    pl_rec  = '{pass: p[15:0], cnt: c[3:0], adm: a[0], lck: l[0]};
    @(negedge clk_i);
    pl_en = 1'b0;
  endtask

  // Record-level rules: locked wins, then password match, else count a failure.
  task automatic model(input int d, input int s, input bit o, input int pt, input int pn,
                       output int st, output int tr, output int adm,
                       output bit wc, output bit wl, output bit wp);
    wc = 0; wl = 0; wp = 0; adm = 0;
    if (rl[d][s] != 0) begin
      st = 2; tr = rc[d][s];
    end else if (rp[d][s] == pt) begin
      st = 0; tr = 0; adm = ra[d][s];
      wc = (rc[d][s] != 0); wp = o;
      rc[d][s] = 0;
      if (o) rp[d][s] = pn;
    end else begin
      tr = (rc[d][s] + 1 > 15) ? 15 : rc[d][s] + 1;
      wc = 1; rc[d][s] = tr;
      if (tr >= max_tries[d]) begin
        wl = 1; rl[d][s] = 1; st = 3;
      end else begin
        st = 1;
      end
    end
  endtask

  task automatic check_record(input int d, input int s);
    mrec_t r;
    r = sram[d][slot_addr[s]];
    check("rec_pass", d, r.pass, rp[d][s]);
    check("rec_cnt", d, r.cnt, rc[d][s]);
    check("rec_lock", d, r.lck, rl[d][s]);
  endtask

  task automatic run(input int s, input bit o, input int pt, input int pn, input bit stray);
    int st [2], tr [2], adm [2];
    bit wc [2], wl [2], wp [2];
    int lat, wr_k;
    for (int d = 0; d < 2; d++) model(d, s, o, pt, pn, st[d], tr[d], adm[d], wc[d], wl[d], wp[d]);
    @(negedge clk_i);
    req = 1'b1; op = o; user_id = slot_addr[s];
    pass_try = pt[15:0]; pass_new = pn[15:0];
    @(negedge clk_i);
    for (int k = 1; k <= 8; k++) begin
      for (int d = 0; d < 2; d++) begin
        lat  = rd_lat[d] + 3;
        wr_k = rd_lat[d] + 2;
        check("busy", d, busy[d], k <= lat);
        check("done", d, done[d], k == lat);
        if (k <= rd_lat[d]) begin
          check("rd_cs", d, cs[d], 1);
          check("rd_rw", d, {prw[d], crw[d], arw[d], lrw[d]}, 0);
          check("rd_addr", d, addr[d], slot_addr[s]);
        end else if (k == wr_k) begin
          check("wr_cs", d, cs[d], wc[d] | wl[d] | wp[d]);
          check("wr_rw", d, {prw[d], crw[d], arw[d], lrw[d]}, {wp[d], wc[d], 1'b0, wl[d]});
          check("wr_addr", d, addr[d], slot_addr[s]);
          if (wc[d]) check("count_wr", d, cwr[d], tr[d]);
          if (wp[d]) check("pass_wr", d, pwr[d], pn[15:0]);
          if (wl[d]) check("lock_wr", d, lwr[d], 1);
        end else begin
          check("idle_cs", d, cs[d], 0);
        end
        if (k >= lat) begin
          check("status", d, status[d], st[d]);
          check("tries", d, tries[d], tr[d]);
          if (st[d] == 0) check("is_admin", d, is_admin[d], adm[d]);
        end
      end
      req = stray && (k <= 3);
      if (req) begin
        user_id  = slot_addr[(s + 1) % 8];
        pass_try = 16'($urandom);
      end
      @(negedge clk_i);
    end
    req = 1'b0;
    for (int d = 0; d < 2; d++) check_record(d, s);
  endtask

  initial begin
    int s, pt;
    bit o;
    // Reset state.
    #12;
    for (int d = 0; d < 2; d++) begin
      check("rst_busy", d, busy[d], 0);
      check("rst_done", d, done[d], 0);
      check("rst_cs", d, cs[d], 0);
      check("rst_rw", d, {prw[d], crw[d], arw[d], lrw[d]}, 0);
      check("rst_status", d, status[d], 0);
      check("rst_admin", d, is_admin[d], 0);
      check("rst_tries", d, tries[d], 0);
      check("rst_addr", d, addr[d], 0);
      check("rst_wr", d, {pwr[d], cwr[d], awr[d], lwr[d]}, 0);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Clean login, failures to lockout, already locked, password change.
    preload(0, 'hBEEF, 0, 1, 0);
    run(0, 0, 'hBEEF, 0, 0);
    preload(1, 'h1234, 1, 0, 0);
    run(1, 0, 'h1235, 0, 0);
    run(1, 0, 'h1235, 0, 1);
    preload(2, 'h4321, 2, 1, 1);
    run(2, 0, 'h4321, 0, 0);
    preload(3, 'hAAAA, 2, 0, 0);
    run(3, 1, 'hAAAA, 'h5555, 0);
    preload(4, 'hAAAA, 2, 0, 0);
    run(4, 1, 'hAAAB, 'h5555, 1);
    preload(5, 'h0F0F, 15, 0, 0);
    run(5, 0, 'h0F0E, 0, 0);
    preload(7, 'h7777, 14, 0, 0);
    run(7, 0, 'h0000, 0, 0);

    // Reset while dut0 sits in WR with a count write and dut1 is still reading.
    preload(6, 'h0F0F, 1, 0, 0);
    @(negedge clk_i);
    req = 1'b1; op = 1'b0; user_id = slot_addr[6]; pass_try = 16'h1111;
    @(negedge clk_i);
    req = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("mid_rst_cs", d, cs[d], 0);
      check("mid_rst_busy", d, busy[d], 0);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 0; k < 8; k++) begin
      for (int d = 0; d < 2; d++) check("no_done_after_rst", d, done[d], 0);
      @(negedge clk_i);
    end
    preload(6, 'h0F0F, 1, 0, 0);
    run(6, 0, 'h1111, 0, 0);

    // Randomised traffic against the record-level model.
    for (int i = 0; i < 40; i++) begin
      s = $urandom_range(0, 7);
      if ($urandom_range(0, 3) == 0)
        preload(s, $urandom_range(0, 65535), $urandom_range(0, 15), $urandom_range(0, 1),
                ($urandom_range(0, 3) == 0) ? 1 : 0);
      o  = 1'($urandom_range(0, 1));
      pt = ($urandom_range(0, 1) == 1) ? rp[$urandom_range(0, 1)][s] : $urandom_range(0, 65535);
      run(s, o, pt, $urandom_range(0, 65535), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
